// File: rtl/exception_sequencer_pkg.sv
// Shared types and constants for the exception sequencer: FSM states,
// vector select codes and the vector table addresses they map to.
package exc_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SAVE_EPC = 3'd1,
        MEM_REQ  = 3'd2,
        MEM_WAIT = 3'd3,
        LOAD_PC  = 3'd4,
        DONE     = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        SEL_OPCODE   = 2'd0,
        SEL_OVERFLOW = 2'd1,
        SEL_DIV_ZERO = 2'd2
    } exc_sel_t;

    localparam logic [7:0] VEC_OPCODE   = 8'd253;
    localparam logic [7:0] VEC_OVERFLOW = 8'd254;
    localparam logic [7:0] VEC_DIV_ZERO = 8'd255;

    localparam int CNT_W = 3;

    function automatic logic [7:0] vec_addr(exc_sel_t sel);
        case (sel)
            SEL_OPCODE:   return VEC_OPCODE;
            SEL_OVERFLOW: return VEC_OVERFLOW;
            default:      return VEC_DIV_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/exception_sequencer_if.sv
// Cause/memory/PC bus between main control and the exception sequencer.
// cause_out exists only when EXC_CAUSE_REG_EN is defined.
interface exception_sequencer_if;
    logic        opcode_invalid;
    logic        overflow;
    logic        div_zero;
    logic [31:0] pc_in;
    logic [31:0] mem_data_in;
    logic        exc_active;
    logic [1:0]  exc_sel;
    logic        mem_read;
    logic        epc_write;
    logic [31:0] epc_out;
    logic        pc_write;
    logic [31:0] pc_out;
    logic        done;
`ifdef EXC_CAUSE_REG_EN
    logic [1:0]  cause_out;
`endif

    modport master (
        input  opcode_invalid, overflow, div_zero, pc_in, mem_data_in,
        output exc_active, exc_sel, mem_read, epc_write, epc_out,
        output pc_write, pc_out, done
`ifdef EXC_CAUSE_REG_EN
        , output cause_out
`endif
    );

    modport slave (
        output opcode_invalid, overflow, div_zero, pc_in, mem_data_in,
        input  exc_active, exc_sel, mem_read, epc_write, epc_out,
        input  pc_write, pc_out, done
`ifdef EXC_CAUSE_REG_EN
        , input cause_out
`endif
    );
endinterface

// File: rtl/exception_sequencer_priority_encoder.sv
// Fixed-priority cause selection: opcode_invalid > overflow > div_zero.
module exc_priority_encoder
    import exc_pkg::*;
(
    input  logic     opcode_invalid,
    input  logic     overflow,
    input  logic     div_zero,
    output logic     valid,
    output exc_sel_t code
);

    always_comb begin
        valid = opcode_invalid | overflow | div_zero;
        code  = SEL_OPCODE;
        if (opcode_invalid)
            code = SEL_OPCODE;
        else if (overflow)
            code = SEL_OVERFLOW;
        else if (div_zero)
            code = SEL_DIV_ZERO;
    end

endmodule

// File: rtl/exception_sequencer.sv
// Exception entry sequencer: save EPC, fetch handler byte from the vector
// table, load PC. Optional cause_out register under EXC_CAUSE_REG_EN.
module exception_sequencer
    import exc_pkg::*;
#(
    parameter int MEM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    exception_sequencer_if.master bus
);

    localparam logic [CNT_W-1:0] LAT = CNT_W'(MEM_LATENCY);

    state_t          state;
    logic [CNT_W-1:0] cnt;
    exc_sel_t        sel_q;
    logic            active_q;
    logic            mem_read_q;
    logic            epc_write_q;
    logic            pc_write_q;
    logic            done_q;
    logic [31:0]     epc_q;
    logic [31:0]     pc_q;
    logic            cause_vld;
    exc_sel_t        cause_code;
    logic            unused_data_hi;

    assign unused_data_hi = ^bus.mem_data_in[31:8];

    exc_priority_encoder u_prio (
        .opcode_invalid (bus.opcode_invalid),
        .overflow       (bus.overflow),
        .div_zero       (bus.div_zero),
        .valid          (cause_vld),
        .code           (cause_code)
    );

    // Outputs are registered alongside the state they belong to, so each
    // strobe is high exactly during its state's cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            sel_q       <= SEL_OPCODE;
            active_q    <= 1'b0;
            mem_read_q  <= 1'b0;
            epc_write_q <= 1'b0;
            pc_write_q  <= 1'b0;
            done_q      <= 1'b0;
            epc_q       <= '0;
            pc_q        <= '0;
        end else begin
            mem_read_q  <= 1'b0;
            epc_write_q <= 1'b0;
            pc_write_q  <= 1'b0;
            done_q      <= 1'b0;
            case (state)
                IDLE: begin
                    if (cause_vld) begin
                        state       <= SAVE_EPC;
                        sel_q       <= cause_code;
                        epc_q       <= bus.pc_in - 32'd4;
                        epc_write_q <= 1'b1;
                        active_q    <= 1'b1;
                    end
                end
                SAVE_EPC: begin
                    state      <= MEM_REQ;
                    mem_read_q <= 1'b1;
                end
                MEM_REQ: begin
                    state <= MEM_WAIT;
                    cnt   <= LAT;
                end
                MEM_WAIT: begin
                    if (cnt <= CNT_W'(1)) begin
                        state      <= LOAD_PC;
                        cnt        <= '0;
                        pc_write_q <= 1'b1;
                        pc_q       <= {24'd0, bus.mem_data_in[7:0]};
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                LOAD_PC: begin
                    state  <= DONE;
                    done_q <= 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    active_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef EXC_CAUSE_REG_EN
    exc_sel_t cause_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cause_q <= SEL_OPCODE;
        else if (state == SAVE_EPC)
            cause_q <= sel_q;
    end

    assign bus.cause_out = cause_q;
`endif

    assign bus.exc_active = active_q;
    assign bus.exc_sel    = sel_q;
    assign bus.mem_read   = mem_read_q;
    assign bus.epc_write  = epc_write_q;
    assign bus.epc_out    = epc_q;
    assign bus.pc_write   = pc_write_q;
    assign bus.pc_out     = pc_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_exception_sequencer.sv
// Directed bench: dut1 uses MEM_LATENCY=1, dut2 uses MEM_LATENCY=4.
module tb_exception_sequencer;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    exception_sequencer_if b1 ();
    exception_sequencer_if b2 ();

    exception_sequencer #(.MEM_LATENCY(1)) dut1 (.clk(clk), .reset(rst), .bus(b1));
    exception_sequencer #(.MEM_LATENCY(4)) dut2 (.clk(clk), .reset(rst), .bus(b2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        int waits;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        b1.opcode_invalid = 1'b0; b1.overflow = 1'b0; b1.div_zero = 1'b0;
        b1.pc_in = 32'h0; b1.mem_data_in = 32'h0;
        b2.opcode_invalid = 1'b0; b2.overflow = 1'b0; b2.div_zero = 1'b0;
        b2.pc_in = 32'h0; b2.mem_data_in = 32'h0;
        #1;
        // reset state
        chk1("rst_active", b1.exc_active, 1'b0);
        chk32("rst_sel", 32'(b1.exc_sel), 32'h0);
        chk32("rst_epc", b1.epc_out, 32'h0);
        chk32("rst_pc", b1.pc_out, 32'h0);
        chk32("rst_strobes", {28'd0, b1.mem_read, b1.epc_write, b1.pc_write, b1.done}, 32'h0);
`ifdef EXC_CAUSE_REG_EN
        chk32("rst_cause_out", 32'(b2.cause_out), 32'h0);
`endif
        tick();
        tick();
        rst = 1'b0;
        tick();

        // overflow, pc 0x40, handler byte 0x12
        b1.overflow = 1'b1; b1.pc_in = 32'h40; b1.mem_data_in = 32'h0000_0012;
        tick();
        b1.overflow = 1'b0;
        chk1("ov_epc_write", b1.epc_write, 1'b1);
        chk32("ov_epc_out", b1.epc_out, 32'h0000_003C);
        chk32("ov_sel", 32'(b1.exc_sel), 32'h1);
        chk1("ov_active", b1.exc_active, 1'b1);
        chk1("ov_no_mem_read_yet", b1.mem_read, 1'b0);
        tick();
        chk1("ov_mem_read", b1.mem_read, 1'b1);
        chk1("ov_epc_write_off", b1.epc_write, 1'b0);
        tick();
        chk32("ov_wait_quiet", {29'd0, b1.mem_read, b1.pc_write, b1.done}, 32'h0);
        tick();
        chk1("ov_pc_write", b1.pc_write, 1'b1);
        chk32("ov_pc_out", b1.pc_out, 32'h0000_0012);
        tick();
        chk1("ov_done", b1.done, 1'b1);
        chk1("ov_pc_write_off", b1.pc_write, 1'b0);
        tick();
        chk1("ov_idle_active", b1.exc_active, 1'b0);
        chk1("ov_done_off", b1.done, 1'b0);

        // opcode_invalid + div_zero together; div_zero held for a second run
        b1.opcode_invalid = 1'b1; b1.div_zero = 1'b1; b1.pc_in = 32'h100; b1.mem_data_in = 32'h55;
        tick();
        b1.opcode_invalid = 1'b0;
        chk32("pri_sel", 32'(b1.exc_sel), 32'h0);
        chk32("pri_epc_out", b1.epc_out, 32'h0000_00FC);
        tick();
        tick();
        tick();
        chk1("pri_pc_write", b1.pc_write, 1'b1);
        chk32("pri_pc_out", b1.pc_out, 32'h0000_0055);
        chk32("pri_sel_held", 32'(b1.exc_sel), 32'h0);
        tick();
        chk1("pri_done", b1.done, 1'b1);
        tick();
        chk1("pri_idle_gap", b1.exc_active, 1'b0);
        b1.mem_data_in = 32'hFFFF_FF9A;
        tick();
        b1.div_zero = 1'b0;
        chk32("rerun_sel", 32'(b1.exc_sel), 32'h2);
        chk1("rerun_epc_write", b1.epc_write, 1'b1);
        tick();
        tick();
        tick();
        chk1("dz_pc_write", b1.pc_write, 1'b1);
        chk32("dz_pc_out", b1.pc_out, 32'h0000_009A);
        tick();
        tick();
        chk1("dz_idle", b1.exc_active, 1'b0);

        // PC 0 wraps to 0xFFFFFFFC
        b1.overflow = 1'b1; b1.pc_in = 32'h0;
        tick();
        b1.overflow = 1'b0;
        chk32("wrap_epc_out", b1.epc_out, 32'hFFFF_FFFC);
        for (int i = 0; i < 5; i++) tick();
        chk1("wrap_idle", b1.exc_active, 1'b0);

        // reset while in MEM_WAIT
        b1.div_zero = 1'b1; b1.pc_in = 32'h200;
        tick();
        b1.div_zero = 1'b0;
        tick();
        tick();
        chk1("mw_active_before_rst", b1.exc_active, 1'b1);
        rst = 1'b1;
        #1;
        chk32("mw_rst_outputs", {b1.exc_active, b1.mem_read, b1.epc_write, b1.pc_write,
                                 b1.done, 25'd0, b1.exc_sel}, 32'h0);
        chk32("mw_rst_epc", b1.epc_out, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk1("mw_rst_no_pc_write", b1.pc_write, 1'b0);
        tick();
        chk1("mw_after_no_pc_write", b1.pc_write, 1'b0);
        chk1("mw_after_idle", b1.exc_active, 1'b0);

        // MEM_LATENCY=4 on dut2
        b2.div_zero = 1'b1; b2.pc_in = 32'h80; b2.mem_data_in = 32'h33;
        tick();
        b2.div_zero = 1'b0;
        chk1("l4_epc_write", b2.epc_write, 1'b1);
        tick();
        chk1("l4_mem_read", b2.mem_read, 1'b1);
        waits = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (b2.pc_write) break;
            waits++;
        end
        chk32("l4_wait_cycles", 32'(waits), 32'd4);
        chk32("l4_pc_out", b2.pc_out, 32'h0000_0033);
        tick();
        chk1("l4_done", b2.done, 1'b1);
`ifdef EXC_CAUSE_REG_EN
        chk32("l4_cause_out", 32'(b2.cause_out), 32'h2);
`endif
        tick();
        chk1("l4_idle", b2.exc_active, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
